// File: rtl/dcache_controller_if.sv
// Pipeline/memory-side bundle of the data cache controller.
// DCACHE_STATS_EN adds the HIT_COUNT/MISS_COUNT statistics outputs.
interface dcache_controller_if;
  logic [3:0]   READ_WRITE;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITE_DATA;
  logic [31:0]  READ_DATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_ACK;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;

  modport slave (
    input  READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_ACK,
    output READ_DATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output HIT_COUNT, MISS_COUNT
  );
  modport master (
    output READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_ACK,
    input  READ_DATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  HIT_COUNT, MISS_COUNT
  );
`else
  modport slave (
    input  READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_ACK,
    output READ_DATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
  modport master (
    output READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_ACK,
    input  READ_DATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
`endif
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Optional hit/miss statistics counters are enabled by DCACHE_STATS_EN.
//
// state      | meaning
// IDLE       | serve hits, detect misses
// WRITEBACK  | dirty victim line written to memory, wait MEM_ACK
// REFILL     | requested line read from memory, wait MEM_ACK
// UPDATE     | one stall cycle after refill, access now hits
module dcache_controller #(
  parameter  int SETS       = 8,
  parameter  int LINE_WORDS = 4,
  localparam int IDX_W      = $clog2(SETS),
  localparam int TAG_W      = 32 - IDX_W - 4,
  localparam int LINE_W     = LINE_WORDS * 32
) (
  input  logic               CLK,
  input  logic               RESET,
  dcache_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_UPDATE} state_e;

  state_e state_q, state_d;

  logic [LINE_W-1:0] data_q [SETS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;
  logic [31:0]       read_data_q, read_data_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        word_sel, byte_sel;

  logic              is_load, is_store, ld_signed, access, hit, load_hit;
  logic [1:0]        size;
  logic [LINE_W-1:0] cur_line, new_line;
  logic [31:0]       cur_word, new_word, ld_ext, wrep;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [3:0]        be;
  logic              store_we, refill_we;

  logic              busywait, mem_read, mem_write;
  logic [27:0]       mem_address;
  logic [LINE_W-1:0] mem_writedata;

  assign idx      = bus.ADDRESS[4 +: IDX_W];
  assign tag      = bus.ADDRESS[31 -: TAG_W];
  assign word_sel = bus.ADDRESS[3:2];
  assign byte_sel = bus.ADDRESS[1:0];

  // size: 0 byte, 1 half, 2 word
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    ld_signed = 1'b0;
    size      = 2'd2;
    case (bus.READ_WRITE)
      4'b1000: begin is_load  = 1'b1; ld_signed = 1'b1; size = 2'd0; end
      4'b1001: begin is_load  = 1'b1; ld_signed = 1'b1; size = 2'd1; end
      4'b1010: begin is_load  = 1'b1; size = 2'd2; end
      4'b1100: begin is_load  = 1'b1; size = 2'd0; end
      4'b1101: begin is_load  = 1'b1; size = 2'd1; end
      4'b1011: begin is_store = 1'b1; size = 2'd0; end
      4'b1110: begin is_store = 1'b1; size = 2'd1; end
      4'b1111: begin is_store = 1'b1; size = 2'd2; end
      default: ;
    endcase
  end

  assign access   = is_load | is_store;
  assign hit      = valid_q[idx] && (tag_q[idx] == tag) && access;
  assign load_hit = hit && is_load;

  assign cur_line = data_q[idx];
  assign cur_word = cur_line[{word_sel, 5'b0} +: 32];
  assign ld_byte  = cur_word[{byte_sel, 3'b0} +: 8];
  assign ld_half  = cur_word[{bus.ADDRESS[1], 4'b0} +: 16];

  always_comb begin
    case (size)
      2'd0:    ld_ext = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_ext = cur_word;
    endcase
  end

  always_comb begin
    case (size)
      2'd0: begin
        be   = 4'b0001 << byte_sel;
        wrep = {4{bus.WRITE_DATA[7:0]}};
      end
      2'd1: begin
        be   = bus.ADDRESS[1] ? 4'b1100 : 4'b0011;
        wrep = {2{bus.WRITE_DATA[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = bus.WRITE_DATA;
      end
    endcase
    new_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) new_word[i*8 +: 8] = wrep[i*8 +: 8];
    end
    new_line = cur_line;
    new_line[{word_sel, 5'b0} +: 32] = new_word;
  end

  // Stores commit only from IDLE so the UPDATE-cycle re-evaluation never writes twice.
  assign store_we  = (state_q == S_IDLE) && hit && is_store;
  assign refill_we = (state_q == S_REFILL) && bus.MEM_ACK;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (access && !hit)
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_REFILL;
      end
      S_WRITEBACK: if (bus.MEM_ACK) state_d = S_REFILL;
      S_REFILL:    if (bus.MEM_ACK) state_d = S_UPDATE;
      S_UPDATE:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state_q)
      S_IDLE: busywait = access && !hit;
      S_WRITEBACK: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {tag_q[idx], idx};
        mem_writedata = cur_line;
      end
      S_REFILL: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {tag, idx};
      end
      S_UPDATE: busywait = 1'b1;
      default: ;
    endcase
  end

  // Tag and data storage carry no reset; valid bits guard their contents.
  always_ff @(posedge CLK) begin
    if (refill_we) begin
      data_q[idx] <= bus.MEM_READDATA;
      tag_q[idx]  <= tag;
    end else if (store_we) begin
      data_q[idx] <= new_line;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    read_data_d = load_hit ? ld_ext : read_data_q;
    if (refill_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (store_we) begin
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      read_data_q <= '0;
    end else begin
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      read_data_q <= read_data_d;
    end
  end

  // A pending miss in IDLE must not show as a stall while reset is held.
  assign bus.BUSYWAIT      = busywait && !RESET;
  assign bus.MEM_READ      = mem_read;
  assign bus.MEM_WRITE     = mem_write;
  assign bus.MEM_ADDRESS   = mem_address;
  assign bus.MEM_WRITEDATA = mem_writedata;
  assign bus.READ_DATA     = load_hit ? ld_ext : read_data_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;
  logic        from_update_q;

  // The IDLE hit right after UPDATE finishes a miss and is not a fresh hit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      from_update_q <= 1'b0;
    end else begin
      from_update_q <= (state_q == S_UPDATE);
      if (state_q == S_IDLE && hit && !from_update_q) hit_count_q <= hit_count_q + 32'd1;
      if (state_q == S_IDLE && access && !hit)        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign bus.HIT_COUNT  = hit_count_q;
  assign bus.MISS_COUNT = miss_count_q;
`endif

endmodule
